// File: rtl/a3000_spi_pkg.sv
// Shared types and frame construction for the A3000 flash-access SPI master.
package a3000_spi_pkg;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_LOCK    = 2'b10,
    OP_RELEASE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_GAP
  } state_e;

  localparam int unsigned FRAME_BITS = 64;

  localparam logic [FRAME_BITS-1:0] LOCK_FRAME    = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [FRAME_BITS-1:0] RELEASE_FRAME = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [FRAME_BITS-1:0] build_frame(
    input op_e         op,
    input logic [21:0] addr,
    input logic [31:0] wdata
  );
    logic [FRAME_BITS-1:0] img;
    img = '0;
    case (op)
      OP_WRITE:   img = {1'b0, 1'b0, addr, wdata, 8'h00};
      OP_READ:    img = {1'b0, 1'b1, addr, 40'h0};
      OP_LOCK:    img = LOCK_FRAME;
      OP_RELEASE: img = RELEASE_FRAME;
      default:    img = '0;
    endcase
    return img;
  endfunction

endpackage

// File: rtl/a3000_flash_spi_master_if.sv
// Command/response handshake between the flash-programming controller and the SPI master.
interface a3000_flash_spi_master_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [21:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  // Requester side
  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  // SPI master side
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/a3000_spi_shifter.sv
// 64-bit frame shift register and bit counter; done flags that the current shift ends the frame.
module a3000_spi_shifter
  import a3000_spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  shift,
  input  logic                  miso,
  output logic [FRAME_BITS-1:0] sr,
  output logic                  done
);

  logic [6:0] bit_cnt;

  assign done = (bit_cnt == 7'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sr      <= frame;
      bit_cnt <= 7'(FRAME_BITS);
    end else if (shift) begin
      sr      <= {sr[FRAME_BITS-2:0], miso};
      bit_cnt <= bit_cnt - 7'd1;
    end
  end

endmodule

// File: rtl/a3000_flash_spi_master.sv
// MCU-side SPI master for the A3000 CPLD flash port: one command -> one 64-bit mode-0 frame.
// Define A3000_SPI_RSP_ALL_EN to pulse rsp_valid after every frame instead of reads only.
module a3000_flash_spi_master
  import a3000_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      nRESET,
  a3000_flash_spi_master_if.slave   bus,
  output logic                      spi_sck,
  output logic                      spi_ss,
  output logic                      spi_mosi,
  input  logic                      spi_miso
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 2);

  state_e                state;
  logic [7:0]            div_cnt;
  op_e                   op_q;
  logic [FRAME_BITS-1:0] frame_img;
  logic [FRAME_BITS-1:0] sr;
  logic                  accept;
  logic                  div_end;
  logic                  shift;
  logic                  done;
  logic                  rsp_en;

  assign accept  = (state == ST_IDLE) && bus.cmd_ready && bus.cmd_valid;
  assign div_end = (div_cnt == DIV_LAST);
  assign shift   = (state == ST_HIGH) && div_end;

  always_comb begin
    frame_img = '0;
    frame_img = build_frame(op_e'(bus.cmd_op), bus.cmd_addr, bus.cmd_wdata);
  end

  always_comb begin
    rsp_en = 1'b0;
`ifdef A3000_SPI_RSP_ALL_EN
    rsp_en = 1'b1;
`else
    rsp_en = (op_q == OP_READ);
`endif
  end

  a3000_spi_shifter u_shifter (
    .clk   (clk),
    .rst_n (nRESET),
    .load  (accept),
    .frame (frame_img),
    .shift (shift),
    .miso  (spi_miso),
    .sr    (sr),
    .done  (done)
  );

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state         <= ST_IDLE;
      div_cnt       <= '0;
      op_q          <= OP_WRITE;
      spi_sck       <= 1'b0;
      spi_ss        <= 1'b1;
      spi_mosi      <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q          <= op_e'(bus.cmd_op);
            spi_ss        <= 1'b0;
            spi_sck       <= 1'b0;
            spi_mosi      <= frame_img[FRAME_BITS-1];
            div_cnt       <= '0;
            bus.cmd_ready <= 1'b0;
            state         <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (div_end) begin
            spi_sck <= 1'b1;
            div_cnt <= '0;
            state   <= ST_HIGH;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        ST_HIGH: begin
          if (div_end) begin
            spi_sck  <= 1'b0;
            spi_mosi <= sr[FRAME_BITS-2];
            div_cnt  <= '0;
            if (done) begin
              spi_ss <= 1'b1;
              if (rsp_en) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_rdata <= {sr[30:0], spi_miso};
              end
              // The IDLE cycle counts as the last SS-high cycle, so a held
              // cmd_valid yields exactly GAP_CYCLES of SS high between frames.
              if (GAP_CYCLES > 1) begin
                state <= ST_GAP;
              end else begin
                bus.cmd_ready <= 1'b1;
                state         <= ST_IDLE;
              end
            end else begin
              state <= ST_LOW;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        ST_GAP: begin
          if (div_cnt == GAP_LAST) begin
            div_cnt       <= '0;
            bus.cmd_ready <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_a3000_flash_spi_master.sv
// Directed bench for a3000_flash_spi_master with a mode-0 slave model and a negedge bus monitor.
module tb_a3000_flash_spi_master;
  import a3000_spi_pkg::*;

  localparam int unsigned CLK_DIV    = 1;
  localparam int unsigned GAP_CYCLES = 4;
  localparam int          LATENCY    = 1 + 128 * CLK_DIV;

  logic clk = 1'b0;
  logic nRESET;
  logic spi_sck, spi_ss, spi_mosi;
  logic spi_miso = 1'b0;

  a3000_flash_spi_master_if bus_if ();

  a3000_flash_spi_master #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk      (clk),
    .nRESET   (nRESET),
    .bus      (bus_if),
    .spi_sck  (spi_sck),
    .spi_ss   (spi_ss),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_asserts = 0;
  int          n_fail = 0;

  logic [63:0] slave_frame = '0;
  logic [63:0] mosi_cap = '0;
  int          slave_idx = 0;
  int          sck_rises = 0;
  int          ss_low = 0;
  int          mosi_viol = 0;
  int          rsp_cnt = 0;
  int          rsp_total = 0;
  logic [31:0] rsp_data = '0;
  int          rsp_cyc = 0;
  int          acc_cyc = 0;
  int          high_run = 0;
  int          last_high_run = 0;
  logic        prev_ss = 1'b1;
  logic        prev_sck = 1'b0;
  logic        prev_mosi = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (prev_ss && !spi_ss) begin
      last_high_run = high_run;
      sck_rises = 0;
      ss_low    = 0;
      mosi_cap  = '0;
      rsp_cnt   = 0;
      slave_idx = 0;
      mosi_viol = 0;
    end
    if (spi_ss) high_run = high_run + 1;
    else begin
      high_run = 0;
      ss_low   = ss_low + 1;
    end
    if (!prev_sck && spi_sck && !spi_ss) begin
      sck_rises = sck_rises + 1;
      mosi_cap  = {mosi_cap[62:0], spi_mosi};
    end
    if (prev_sck && spi_sck && (spi_mosi !== prev_mosi)) mosi_viol = mosi_viol + 1;
    if (prev_sck && !spi_sck && !spi_ss) slave_idx = slave_idx + 1;
    spi_miso = (!spi_ss && slave_idx < 64) ? slave_frame[63 - slave_idx] : 1'b0;
    if (bus_if.rsp_valid) begin
      rsp_cnt   = rsp_cnt + 1;
      rsp_total = rsp_total + 1;
      rsp_data  = bus_if.rsp_rdata;
      rsp_cyc   = cyc;
    end
    if (bus_if.cmd_valid && bus_if.cmd_ready) acc_cyc = cyc;
    prev_ss   = spi_ss;
    prev_sck  = spi_sck;
    prev_mosi = spi_mosi;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [21:0] addr, input logic [31:0] wdata,
                      input bit keep_valid);
    int n;
    @(negedge clk);
    bus_if.cmd_op    = op;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_wdata = wdata;
    bus_if.cmd_valid = 1'b1;
    n = 0;
    while (!bus_if.cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 64'(n >= 2000), 64'd0);
    @(posedge clk);
    #1;
    if (!keep_valid) bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while (spi_ss && n < 50) begin
      @(negedge clk);
      n++;
    end
    while (!spi_ss && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("frame_timeout", 64'(n >= 2000), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input logic [63:0] exp_frame, input int exp_rsp);
    check({tag, "_mosi"}, mosi_cap, exp_frame);
    check({tag, "_rises"}, 64'(sck_rises), 64'd64);
    check({tag, "_ss_low"}, 64'(ss_low), 64'(128 * CLK_DIV));
    check({tag, "_mosi_stable"}, 64'(mosi_viol), 64'd0);
    check({tag, "_rsp_cnt"}, 64'(rsp_cnt), 64'(exp_rsp));
    if (exp_rsp != 0) check({tag, "_latency"}, 64'(rsp_cyc - acc_cyc), 64'(LATENCY));
  endtask

  int          exp_all;
  int          base_total;
  logic [63:0] exp_frame;
  logic [31:0] prev_rdata;

  initial begin
`ifdef A3000_SPI_RSP_ALL_EN
    exp_all = 1;
`else
    exp_all = 0;
`endif
    nRESET           = 1'b0;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op    = '0;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss", 64'(spi_ss), 64'd1);
    check("rst_sck", 64'(spi_sck), 64'd0);
    check("rst_mosi", 64'(spi_mosi), 64'd0);
    check("rst_ready", 64'(bus_if.cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
    check("rst_rdata", 64'(bus_if.rsp_rdata), 64'd0);
    @(negedge clk);
    nRESET = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_ss", 64'(spi_ss), 64'd1);
    check("idle_sck", 64'(spi_sck), 64'd0);
    check("idle_ready", 64'(bus_if.cmd_ready), 64'd1);
    check("idle_rsp", 64'(rsp_total), 64'd0);

    // Lock frame
    slave_frame = '0;
    send(2'b10, 22'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("busy_ready", 64'(bus_if.cmd_ready), 64'd0);
    wait_frame();
    exp_frame = 64'h7FFF_FFFF_FFFF_FFFF;
    check_frame("lock", exp_frame, exp_all);

    // Write frame
    send(2'b00, 22'h051234, 32'h12345678, 1'b0);
    wait_frame();
    exp_frame = {2'b00, 22'h051234, 32'h12345678, 8'h00};
    check_frame("write", exp_frame, exp_all);

    // Read frame
    slave_frame = {32'hA5A5A5A5, 32'h42424242};
    send(2'b01, 22'h070F0F, 32'hFFFFFFFF, 1'b0);
    wait_frame();
    exp_frame = {2'b01, 22'h070F0F, 40'h0};
    check_frame("read", exp_frame, 1);
    check("read_rdata", 64'(rsp_data), 64'h42424242);

    // Back-to-back with cmd_valid held: lock then write
    slave_frame = '0;
    send(2'b10, 22'h0, 32'h0, 1'b1);
    bus_if.cmd_op    = 2'b00;
    bus_if.cmd_addr  = 22'h155555;
    bus_if.cmd_wdata = 32'hCAFEF00D;
    wait_frame();
    send(2'b00, 22'h155555, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    check("b2b_gap", 64'(last_high_run), 64'(GAP_CYCLES));
    wait_frame();
    exp_frame = {2'b00, 22'h155555, 32'hCAFEF00D, 8'h00};
    check_frame("b2b_write", exp_frame, exp_all);

    // Reset during bit 30 of a read
    slave_frame = {32'h0, 32'h13579BDF};
    base_total  = rsp_total;
    send(2'b01, 22'h2AAAAA, 32'h0, 1'b0);
    begin
      int n;
      n = 0;
      while (sck_rises < 34 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("abort_timeout", 64'(n >= 2000), 64'd0);
    end
    check("abort_pre_ss", 64'(spi_ss), 64'd0);
    #1;
    nRESET = 1'b0;
    #1;
    check("abort_ss", 64'(spi_ss), 64'd1);
    check("abort_sck", 64'(spi_sck), 64'd0);
    check("abort_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
    repeat (3) @(negedge clk);
    nRESET = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_rsp", 64'(rsp_total - base_total), 64'd0);
    check("abort_ready", 64'(bus_if.cmd_ready), 64'd1);

    slave_frame = {32'hFFFF0000, 32'h42424242};
    send(2'b01, 22'h070F0F, 32'h0, 1'b0);
    wait_frame();
    exp_frame = {2'b01, 22'h070F0F, 40'h0};
    check_frame("read2", exp_frame, 1);
    check("read2_rdata", 64'(rsp_data), 64'h42424242);

    // Release with slave returning DEADBEEF
    prev_rdata  = bus_if.rsp_rdata;
    slave_frame = {32'h0, 32'hDEADBEEF};
    send(2'b11, 22'h0, 32'h0, 1'b0);
    wait_frame();
    exp_frame = 64'hFFFF_FFFF_FFFF_FFFF;
    check_frame("release", exp_frame, exp_all);
    if (exp_all != 0) check("release_rdata", 64'(bus_if.rsp_rdata), 64'hDEADBEEF);
    else check("release_rdata_held", 64'(bus_if.rsp_rdata), 64'(prev_rdata));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/a3000_flash_spi_master.md
# a3000_flash_spi_master

MCU-side SPI master for the A3000 ROM emulator CPLD's flash-access port. Converts single-beat commands (flash write, flash read, lock ARM out, release ARM) into 64-bit SPI frames. Shifts each frame MSB-first on SCK/SS/MOSI and captures MISO. Returns read data to the requester. Sits in the MCU fabric between the flash-programming controller and the cpld_SCK/cpld_SS/cpld_MOSI/cpld_MISO pins.

## Interface
- CLK_DIV, 2: clk cycles per SCK half-period; legal range 1..255.
- GAP_CYCLES, 4: minimum clk cycles SS stays high between frames; legal range 1..255.

- clk  in  1  system clock; all logic on rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  00 write, 01 read, 10 lock (disable ARM access), 11 release (enable ARM access).
- cmd_addr  in  22  flash word address.
- cmd_wdata  in  32  write data; ignored unless op=00.
- rsp_valid  out  1  one-cycle pulse; rsp_rdata valid.
- rsp_rdata  out  32  last 32 bits shifted in from MISO.
- spi_sck  out  1  SPI clock, idle low (mode 0).
- spi_ss  out  1  slave select, active low.
- spi_mosi  out  1  master out.
- spi_miso  in  1  master in; treated as synchronous to clk.

## Operation
- Frame images, bit 63 first:
  - write: {1'b0, 1'b0, addr[21:0], wdata[31:0], 8'h00}
  - read: {1'b0, 1'b1, addr[21:0], 40'h0}; the read data is frame bits [31:0] as received.
  - lock: 64'h7FFF_FFFF_FFFF_FFFF.
  - release: 64'hFFFF_FFFF_FFFF_FFFF.
- Command handshake:
  - A command is accepted on a cycle with cmd_valid & cmd_ready.
  - All cmd_* inputs are captured at acceptance.
- States: IDLE, LOW, HIGH, GAP.
  - IDLE: cmd_ready=1. On accept: load shift register with the frame image, spi_ss<=0, spi_mosi<=image[63], spi_sck<=0, bit counter<=64, go to LOW.
  - LOW: hold for CLK_DIV cycles, then spi_sck<=1 and go to HIGH.
  - HIGH, after CLK_DIV cycles, all of the following in one cycle:
    - spi_sck<=0.
    - Shift register <= {sr[62:0], spi_miso}.
    - spi_mosi <= sr[62].
    - Decrement the counter.
    - If the counter reaches 0: spi_ss<=1, rsp_rdata<={sr[30:0], spi_miso}, pulse rsp_valid, go to GAP. Otherwise go to LOW.
  - GAP: spi_ss high for GAP_CYCLES cycles, then go to IDLE.
- cmd_ready is 0 in every state except IDLE.
- A cmd_valid that is held through a busy frame is accepted on the first IDLE cycle.
- rsp_valid has no back-pressure. The requester must take the pulse.

## Timing
- Reset values: spi_ss=1, spi_sck=0, spi_mosi=0, cmd_ready=1, rsp_valid=0, rsp_rdata=0. The state machine is in IDLE.
- Assertion of nRESET mid-frame aborts immediately: SS rises asynchronously and no rsp_valid is produced.
- SS falls on cycle T+1, where T is the accept cycle.
- The first SCK rise is at T+1+CLK_DIV.
- SS is low for exactly 128*CLK_DIV cycles.
- SS rises and rsp_valid pulses on the same cycle, T+1+128*CLK_DIV.
- The earliest next accept is GAP_CYCLES cycles after SS rises.
- MOSI changes only on cycles where SCK falls (or at SS fall). MOSI is stable for the whole SCK-high phase.
- MISO is sampled on the cycle that ends each high phase.
- Per-frame latency, accept to rsp_valid: 1+128*CLK_DIV cycles.

## Configuration
- A3000_SPI_RSP_ALL_EN:
  - Defined: rsp_valid pulses at the end of every frame, for all four ops. rsp_rdata holds the captured bits [31:0], used for link diagnostics.
  - Undefined: rsp_valid pulses only for read (op=01). For other ops, rsp_rdata is not updated.

## Structure
- Package a3000_spi_pkg:
  - op enum (OP_WRITE, OP_READ, OP_LOCK, OP_RELEASE).
  - FRAME_BITS=64.
  - LOCK_FRAME and RELEASE_FRAME constants.
  - Function build_frame(op, addr, wdata).
- One sub-module, a3000_spi_shifter: the 64-bit shift register and bit counter, with load/shift/done ports. The top keeps the state machine and the divider.

## Test plan
- Reset, then 10 idle cycles -> spi_ss=1, spi_sck=0, cmd_ready=1, no rsp_valid.
- CLK_DIV=1, op=lock:
  - MOSI bits sampled at SCK rises equal 64'h7FFF_FFFF_FFFF_FFFF.
  - SS is low for 128 cycles.
  - 64 SCK rises.
- op=write, addr=22'h051234, wdata=32'h12345678 -> MOSI frame = {2'b00, 22'h051234, 32'h12345678, 8'h00}.
- op=read, addr=22'h070F0F, slave model drives 32'h42424242 in frame bits [31:0] -> one rsp_valid with rsp_rdata=32'h42424242.
- Back-to-back commands with cmd_valid held high, GAP_CYCLES=4 -> SS high for exactly 4 cycles between frames. Second frame correct.
- nRESET asserted at bit 30 of a read:
  - SS high immediately, no rsp_valid.
  - The next read completes normally.
- With A3000_SPI_RSP_ALL_EN, op=release and the slave returning 32'hDEADBEEF -> rsp_valid with that value. Without the macro, no pulse.
